// File: rtl/kf8259_common_package.sv
// kf8259_common_package: OCW2 command codes and bit helpers shared by the resolver and in-service control
package kf8259_common_package;
  localparam logic [2:0] OCW2_AEOI_ROT_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_AEOI_ROT_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIORITY = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  typedef enum logic {IDLE, ACK_PENDING} isc_state_t;

  function automatic logic [7:0] rotate_right(input logic [7:0] s, input logic [2:0] r);
    logic [15:0] d;
    d = {s, s} >> r;
    return d[7:0];
  endfunction

  function automatic logic [7:0] rotate_left(input logic [7:0] s, input logic [2:0] r);
    logic [15:0] d;
    d = {s, s} << r;
    return d[15:8];
  endfunction

  function automatic logic [7:0] resolve_priority(input logic [7:0] s);
    return s & (~s + 8'd1);
  endfunction

  function automatic logic [7:0] num2bit(input logic [2:0] n);
    return 8'd1 << n;
  endfunction

  function automatic logic [2:0] bit2num(input logic [7:0] s);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 8; i++) if (s[i]) n = 3'(i);
    return n;
  endfunction
endpackage

// File: rtl/kf8259_in_service_control.sv
// kf8259_in_service_control: ISR, EOI/OCW2 decode, auto-EOI and priority rotation for the KF8259
module kf8259_in_service_control
  import kf8259_common_package::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt,
  input  logic       ack_first,
  input  logic       ack_last,
  input  logic       auto_eoi_config,
  input  logic       icw1_write,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [2:0] priority_rotate,
  output logic [7:0] interrupt_to_clear,
  output logic [2:0] acked_level,
  output logic       spurious
);
  isc_state_t state;
  logic       rotate_in_aeoi;
  logic [2:0] amt, cmd, lvl, rotate_next;
  logic [7:0] set_mask, ocw_clear, aeoi_clear;
  logic       ack_start, ack_end, aeoi_done, ocw_rot;
  logic       unused_ocw2;

  assign unused_ocw2 = ^ocw2_data[4:3];
  assign amt = priority_rotate + 3'd1;
  assign highest_level_in_service =
    rotate_left(resolve_priority(rotate_right(in_service_register, amt)), amt);
  assign cmd = ocw2_data[7:5];
  assign lvl = ocw2_data[2:0];

  always_comb begin
    ack_start  = state == IDLE && ack_first;
    ack_end    = state == ACK_PENDING && ack_last;
    aeoi_done  = ack_end && auto_eoi_config && !spurious;
    set_mask   = ack_start ? interrupt : 8'd0;
    aeoi_clear = aeoi_done ? num2bit(acked_level) : 8'd0;
    ocw_clear  = !ocw2_write ? 8'd0 :
                 (cmd == OCW2_NS_EOI || cmd == OCW2_ROT_NS_EOI) ? highest_level_in_service :
                 (cmd == OCW2_SP_EOI || cmd == OCW2_ROT_SP_EOI) ? num2bit(lvl) : 8'd0;
    // Non-specific rotate only happens when there was something in service to retire
    ocw_rot    = ocw2_write && ((cmd == OCW2_ROT_NS_EOI && highest_level_in_service != 8'd0) ||
                 cmd == OCW2_ROT_SP_EOI || cmd == OCW2_SET_PRIORITY);
    rotate_next = ocw_rot ? (cmd == OCW2_ROT_NS_EOI ? bit2num(highest_level_in_service) : lvl) :
                  (aeoi_done && rotate_in_aeoi) ? acked_level : priority_rotate;
  end

  always_ff @(posedge clock, posedge reset) begin
    if (reset) begin
      state               <= IDLE;
      in_service_register <= 8'd0;
      priority_rotate     <= 3'b111;
      rotate_in_aeoi      <= 1'b0;
      interrupt_to_clear  <= 8'd0;
      acked_level         <= 3'd0;
      spurious            <= 1'b0;
    end else if (icw1_write) begin
      state               <= IDLE;
      in_service_register <= 8'd0;
      priority_rotate     <= 3'b111;
      rotate_in_aeoi      <= 1'b0;
      interrupt_to_clear  <= 8'd0;
      acked_level         <= 3'd0;
      spurious            <= 1'b0;
    end else begin
      in_service_register <= (in_service_register & ~(ocw_clear | aeoi_clear)) | set_mask;
      priority_rotate     <= rotate_next;
      interrupt_to_clear  <= set_mask;
      if (ocw2_write && cmd == OCW2_AEOI_ROT_SET) rotate_in_aeoi <= 1'b1;
      if (ocw2_write && cmd == OCW2_AEOI_ROT_CLR) rotate_in_aeoi <= 1'b0;
      if (ack_start) begin
        state       <= ACK_PENDING;
        acked_level <= interrupt != 8'd0 ? bit2num(interrupt) : 3'd7;
        spurious    <= interrupt == 8'd0;
      end else if (ack_end) begin
        state    <= IDLE;
        spurious <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_kf8259_in_service_control.sv
// tb_kf8259_in_service_control: directed checks of ISR, EOI, AEOI, rotation and reset behaviour
module tb_kf8259_in_service_control;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] interrupt = 8'd0;
  logic       ack_first = 1'b0, ack_last = 1'b0, auto_eoi_config = 1'b0;
  logic       icw1_write = 1'b0, ocw2_write = 1'b0;
  logic [7:0] ocw2_data = 8'd0;
  logic [7:0] isr, highest, clr;
  logic [2:0] rot, acked;
  logic       spur;
  int         errors = 0, checks = 0;

  kf8259_in_service_control dut (
    .clock(clock), .reset(reset), .interrupt(interrupt), .ack_first(ack_first),
    .ack_last(ack_last), .auto_eoi_config(auto_eoi_config), .icw1_write(icw1_write),
    .ocw2_write(ocw2_write), .ocw2_data(ocw2_data), .in_service_register(isr),
    .highest_level_in_service(highest), .priority_rotate(rot), .interrupt_to_clear(clr),
    .acked_level(acked), .spurious(spur)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    ack_first = 1'b0; ack_last = 1'b0; icw1_write = 1'b0; ocw2_write = 1'b0;
  endtask

  task automatic ocw2(input logic [7:0] d);
    ocw2_write = 1'b1; ocw2_data = d;
    tick();
  endtask

  task automatic ack(input logic [7:0] irq);
    interrupt = irq; ack_first = 1'b1;
    tick();
    interrupt = 8'd0; ack_last = 1'b1;
    tick();
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst_isr", isr, 8'h00);
    chk("rst_rot", {5'd0, rot}, 8'h07);
    chk("rst_highest", highest, 8'h00);
    chk("rst_clr", clr, 8'h00);
    chk("rst_acked", {5'd0, acked}, 8'h00);
    chk("rst_spur", {7'd0, spur}, 8'h00);

    interrupt = 8'h04; ack_first = 1'b1; tick(); interrupt = 8'h00;
    chk("ack2_isr", isr, 8'h04);
    chk("ack2_level", {5'd0, acked}, 8'h02);
    chk("ack2_clr", clr, 8'h04);
    chk("ack2_spur", {7'd0, spur}, 8'h00);
    tick();
    chk("ack2_clr_gone", clr, 8'h00);
    ack_last = 1'b1; tick();
    chk("ack2_isr_kept", isr, 8'h04);
    chk("ack2_highest", highest, 8'h04);
    ocw2(8'h20);
    chk("nseoi_isr", isr, 8'h00);

    ocw2(8'hC0);
    chk("setpri_rot", {5'd0, rot}, 8'h00);
    ack(8'h01); ack(8'h80);
    chk("two_isr", isr, 8'h81);
    chk("rot0_highest", highest, 8'h80);
    ocw2(8'hA0);
    chk("rnseoi_isr", isr, 8'h01);
    chk("rnseoi_rot", {5'd0, rot}, 8'h07);
    ocw2(8'h20);
    chk("nseoi2_isr", isr, 8'h00);

    auto_eoi_config = 1'b1;
    ocw2(8'h80);
    interrupt = 8'h08; ack_first = 1'b1; tick(); interrupt = 8'h00;
    chk("aeoi_isr_set", isr, 8'h08);
    chk("aeoi_level", {5'd0, acked}, 8'h03);
    ack_last = 1'b1; tick();
    chk("aeoi_isr_clr", isr, 8'h00);
    chk("aeoi_rot", {5'd0, rot}, 8'h03);

    ack_first = 1'b1; tick();
    chk("spur_level", {5'd0, acked}, 8'h07);
    chk("spur_flag", {7'd0, spur}, 8'h01);
    chk("spur_isr", isr, 8'h00);
    chk("spur_clr", clr, 8'h00);
    ack_last = 1'b1; tick();
    chk("spur_end", {7'd0, spur}, 8'h00);
    chk("spur_no_rot", {5'd0, rot}, 8'h03);

    auto_eoi_config = 1'b0;
    ocw2(8'h00);
    ack(8'h02);
    chk("pre_same_isr", isr, 8'h02);
    interrupt = 8'h02; ack_first = 1'b1; ocw2_write = 1'b1; ocw2_data = 8'h61; tick();
    interrupt = 8'h00;
    chk("same_cycle_isr", isr, 8'h02);
    chk("same_cycle_level", {5'd0, acked}, 8'h01);
    ack_last = 1'b1; tick();

    ocw2(8'h61);
    chk("speoi_isr", isr, 8'h00);
    ocw2(8'hA0);
    chk("rnseoi_empty_rot", {5'd0, rot}, 8'h03);
    ocw2(8'hE5);
    chk("rspeoi_clear_bit_rot", {5'd0, rot}, 8'h05);
    chk("rspeoi_clear_bit_isr", isr, 8'h00);

    interrupt = 8'h10; ack_first = 1'b1; tick(); interrupt = 8'h00;
    chk("icw_pre_isr", isr, 8'h10);
    icw1_write = 1'b1; tick();
    chk("icw_isr", isr, 8'h00);
    chk("icw_rot", {5'd0, rot}, 8'h07);
    chk("icw_acked", {5'd0, acked}, 8'h00);
    chk("icw_clr", clr, 8'h00);
    auto_eoi_config = 1'b1;
    ocw2(8'h80);
    ack_last = 1'b1; tick();
    chk("icw_late_last_rot", {5'd0, rot}, 8'h07);

    interrupt = 8'h20; ack_first = 1'b1; tick(); interrupt = 8'h00;
    chk("arst_pre_isr", isr, 8'h20);
    #2 reset = 1'b1;
    #1 chk("arst_isr_async", isr, 8'h00);
    chk("arst_spur_async", {7'd0, spur}, 8'h00);
    @(posedge clock); #1 reset = 1'b0;
    ocw2(8'h80);
    ack_last = 1'b1; tick();
    chk("arst_late_last_rot", {5'd0, rot}, 8'h07);
    chk("arst_late_last_isr", isr, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kf8259_in_service_control.md
Name: kf8259_in_service_control

Overview:
- Downstream stage of the KF8259 priority resolver. Consumes its one-hot `interrupt` output during the INTA sequence.
- Owns the in-service register (ISR), highest-level-in-service tracking, EOI handling (OCW2), auto-EOI and priority rotation state.
- Feeds `in_service_register`, `highest_level_in_service` and `priority_rotate` back to the resolver.
- Feeds the acknowledged level to the vector/data-bus logic and the clear mask to the IRR.

Parameters:
- none (8 interrupt levels fixed)

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- interrupt  input  8  one-hot winning request from the priority resolver; 0 = none
- ack_first  input  1  one-cycle pulse, start of first INTA
- ack_last  input  1  one-cycle pulse, end of last INTA
- auto_eoi_config  input  1  ICW4 AEOI bit
- icw1_write  input  1  one-cycle pulse, initialization restart
- ocw2_write  input  1  one-cycle pulse, OCW2 written
- ocw2_data  input  8  [7:5] = R,SL,EOI; [2:0] = level L
- in_service_register  output  8  ISR
- highest_level_in_service  output  8  one-hot highest-priority ISR bit under current rotation; 0 if ISR empty
- priority_rotate  output  3  lowest-priority level; 3'b111 = IR0 highest
- interrupt_to_clear  output  8  one-cycle IRR clear mask
- acked_level  output  3  level latched at ack_first
- spurious  output  1  high from ack_first with interrupt==0 until ack_last

Behaviour:
- Reset and icw1_write give identical results:
  - ISR=0, priority_rotate=3'b111, rotate_in_aeoi=0, FSM=IDLE.
  - interrupt_to_clear=0, acked_level=0, spurious=0.
  - icw1_write takes priority over every other event in that cycle.
- All state is registered; updates are visible one cycle after the input pulse.
- highest_level_in_service is combinational from registered ISR and priority_rotate:
  - Rotate ISR right by (priority_rotate+1) mod 8.
  - Isolate the lowest set bit.
  - Rotate back left by the same amount.
- FSM IDLE, on ack_first:
  - If interrupt!=0: ISR |= interrupt; acked_level = bit2num(interrupt); interrupt_to_clear = interrupt for exactly 1 cycle; spurious=0.
  - If interrupt==0: acked_level=7; spurious=1; ISR unchanged; no clear pulse.
  - Go to ACK_PENDING.
- FSM ACK_PENDING, on ack_last:
  - If auto_eoi_config and !spurious: clear ISR bit acked_level.
  - If additionally rotate_in_aeoi: priority_rotate = acked_level.
  - spurious=0; go to IDLE.
- FSM ACK_PENDING, ack_first: ignored.
- FSM IDLE, ack_last: ignored.
- OCW2 decode when ocw2_write, by ocw2_data[7:5]:
  - 001 non-specific EOI: clear the highest_level_in_service bit.
  - 011 specific EOI: clear ISR bit L.
  - 101 rotate on non-specific EOI: clear the highest bit; priority_rotate = its level.
  - 111 rotate on specific EOI: clear bit L; priority_rotate = L.
  - 110 set priority: priority_rotate = L; ISR unchanged.
  - 100: rotate_in_aeoi=1.
  - 000: rotate_in_aeoi=0.
  - 010: no operation.
- OCW2 boundary cases:
  - Non-specific EOI (plain or rotate) with ISR==0: no change, and no rotate.
  - Specific EOI on an already-clear bit: no change, but the rotate still applies for 111.
- Simultaneous events:
  - ISR_next = (ISR & ~clear_mask) | set_mask. A set wins when set and clear hit the same bit.
  - The non-specific clear target is computed from the pre-update ISR.
  - When an OCW2 rotate and an AEOI rotate occur in the same cycle, the OCW2 rotate wins.
- Reset asserted mid-sequence: FSM returns to IDLE; the pending ack_last has no effect after reset.

Decomposition:
- kf8259_common_package holds:
  - OCW2 command code constants.
  - Functions rotate_right, rotate_left, resolve_priority (isolate lowest set bit), num2bit, bit2num.
- These are shared with the priority resolver.
- No sub-module; the FSM and ISR logic live in a single module.

Test Plan:
- Reset → ISR=8'h00, priority_rotate=3'b111, highest=8'h00, outputs 0.
- interrupt=8'b00000100, ack_first then ack_last, AEOI=0 → ISR=8'b00000100, acked_level=2, one-cycle interrupt_to_clear=8'b00000100. Then OCW2 8'h20 → ISR=0.
- ISR=8'b10000001, priority_rotate=0 (IR1 highest) → highest=8'b10000000. OCW2 8'hA0 → ISR=8'b00000001, priority_rotate=7.
- AEOI=1, OCW2 8'h80, then acknowledge interrupt=8'b00001000 → ISR returns 0 after ack_last; priority_rotate=3.
- ack_first with interrupt=0 → acked_level=7, spurious=1, ISR unchanged, no clear pulse. After ack_last → spurious=0.
- Same cycle: ack_first with interrupt=8'b00000010 plus OCW2 8'h61 (specific EOI on L=1), ISR=8'b00000010 beforehand → ISR stays 8'b00000010. Separately, icw1_write during ACK_PENDING → full reset state, and the later ack_last has no effect.
